// File: rtl/mem_access_sequencer_if.sv
// Avalon-style memory bus between the access sequencer (master) and memory (slave).
interface mem_access_sequencer_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Memory-side sequencer: fetch/load/store bus transactions, completion strobes and PC.
// Optional MEM_TIMEOUT_EN: abort to HALTED with sticky bus_error after TIMEOUT_CYCLES stalls.
module mem_access_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'hBFC00000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch,
    input  logic                           MemRead,
    input  logic                           MemWrite,
    input  logic                           JRcontrol,
    input  logic [31:0]                    alu_result,
    input  logic [31:0]                    store_data,
    input  logic [31:0]                    pc_next,
    mem_access_sequencer_if.master         bus,
    output logic [31:0]                    inst,
    output logic [31:0]                    load_data,
    output logic                           end_of_inst_reg,
    output logic                           end_of_inst_store,
    output logic [31:0]                    pc,
    output logic                           active,
    output logic                           bus_error
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_EXEC    = 4'd2,
        S_LOAD    = 4'd3,
        S_STORE   = 4'd4,
        S_RET_REG = 4'd5,
        S_RET_ST  = 4'd6,
        S_RET_JR  = 4'd7,
        S_COMMIT  = 4'd8,
        S_HALTED  = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, load_data_q, load_data_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        active_q, active_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic        eoi_reg_q, eoi_reg_d, eoi_st_q, eoi_st_d;
    logic        accept_s, stall_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_error_q, bus_error_d;
`endif

    assign accept_s = (mem_read_q | mem_write_q) & ~bus.mem_waitrequest;
    assign stall_s  = (mem_read_q | mem_write_q) &  bus.mem_waitrequest;

    // Next-state and registered-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        load_data_d = load_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        active_d    = active_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        eoi_reg_d   = 1'b0;
        eoi_st_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch && active_q) begin
                    state_d    = S_FETCH;
                    mem_read_d = 1'b1;
                    addr_d     = {pc_q[31:2], 2'b00};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (accept_s) begin
                    inst_d     = bus.mem_readdata;
                    mem_read_d = 1'b0;
                    state_d    = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // Load wins over store when both are asserted
            S_EXEC: begin
                if (JRcontrol) begin
                    state_d = S_RET_JR;
                end else if (MemRead) begin
                    state_d    = S_LOAD;
                    mem_read_d = 1'b1;
                    addr_d     = {alu_result[31:2], 2'b00};
                end else if (MemWrite) begin
                    state_d     = S_STORE;
                    mem_write_d = 1'b1;
                    addr_d      = {alu_result[31:2], 2'b00};
                    wdata_d     = store_data;
                end else begin
                    state_d   = S_RET_REG;
                    eoi_reg_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    load_data_d = bus.mem_readdata;
                    mem_read_d  = 1'b0;
                    state_d     = S_RET_REG;
                    eoi_reg_d   = 1'b1;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_STORE: begin
                if (accept_s) begin
                    mem_write_d = 1'b0;
                    state_d     = S_RET_ST;
                    eoi_st_d    = 1'b1;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_RET_REG, S_RET_ST, S_RET_JR: begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                pc_d = pc_next;
                if (pc_next == 32'd0) begin
                    active_d = 1'b0;
                    state_d  = S_HALTED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d     = S_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase

`ifdef MEM_TIMEOUT_EN
        bus_error_d = bus_error_q;
        if (stall_s) begin
            wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (wait_cnt_d == TIMEOUT_CNT) begin
                wait_cnt_d  = {CNT_W{1'b0}};
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                bus_error_d = 1'b1;
                active_d    = 1'b0;
                state_d     = S_HALTED;
            end else begin
                wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wait_cnt_d = {CNT_W{1'b0}};
        end
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            load_data_q <= 32'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            active_q    <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            eoi_reg_q   <= 1'b0;
            eoi_st_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q  <= {CNT_W{1'b0}};
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            load_data_q <= load_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            active_q    <= active_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            eoi_reg_q   <= eoi_reg_d;
            eoi_st_q    <= eoi_st_d;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign bus_error = bus_error_q;
`else
    assign bus_error = 1'b0;
`endif

    assign bus.mem_address    = addr_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_byteenable = 4'b1111;
    assign inst               = inst_q;
    assign load_data          = load_data_q;
    assign end_of_inst_reg    = eoi_reg_q;
    assign end_of_inst_store  = eoi_st_q;
    assign pc                 = pc_q;
    assign active             = active_q;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Memory-side responder to the CPU control decoder.
- Consumes fetch, MemRead, MemWrite and JRcontrol, and runs the matching Avalon-style memory transactions on the shared bus.
- Returns the fetched instruction and the load data to the datapath.
- Generates the end_of_inst_reg and end_of_inst_store completion strobes that the decoder waits on, and owns the PC register.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum consecutive waitrequest cycles tolerated (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch  in  1  decoder requests an instruction fetch.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store.
- JRcontrol  in  1  current instruction is a jump-register.
- alu_result  in  32  effective address for load/store.
- store_data  in  32  rt value for a store.
- pc_next  in  32  next PC computed by the datapath.
- mem_address  out  32  bus address, word-aligned (bits [1:0] forced 0).
- mem_read  out  1  bus read request.
- mem_write  out  1  bus write request.
- mem_writedata  out  32  bus write data.
- mem_byteenable  out  4  always 4'b1111.
- mem_readdata  in  32  bus read data, valid in the cycle the read is accepted.
- mem_waitrequest  in  1  bus stall.
- inst  out  32  instruction register.
- load_data  out  32  latched load result.
- end_of_inst_reg  out  1  one-cycle pulse: register-writing instruction retired.
- end_of_inst_store  out  1  one-cycle pulse: store retired.
- pc  out  32  current PC.
- active  out  1  high while the CPU is running.
- bus_error  out  1  sticky timeout flag (tied 0 without MEM_TIMEOUT_EN).

Behaviour:
- Reset values, applied at the first rising edge with reset=1:
  - state=IDLE, pc=RESET_PC, inst=0, load_data=0, active=1, bus_error=0.
  - mem_read, mem_write and both end_of_inst strobes = 0.
  - mem_address=0, mem_writedata=0.
- Reset mid-transaction: request lines drop at that edge; no strobe is emitted; any partial data is discarded.
- Bus rule: a request is accepted in a cycle where it is high and mem_waitrequest=0. Address, data and request are held stable until acceptance.
- States:
  - IDLE: if fetch=1 and active=1, go to FETCH.
  - FETCH: mem_read=1, mem_address=pc. On accept, inst<=mem_readdata, then go to EXEC.
  - EXEC: exactly one cycle for decode and ALU settle. Then branch in priority order:
    - JRcontrol=1 goes to RETIRE_JR.
    - MemRead=1 goes to LOAD. MemRead and MemWrite both high is treated as a load and the write is ignored.
    - MemWrite=1 goes to STORE.
    - Otherwise go to RETIRE_REG.
  - LOAD: mem_read=1, mem_address=alu_result. On accept, load_data<=mem_readdata, then go to RETIRE_REG.
  - STORE: mem_write=1, mem_address=alu_result, mem_writedata=store_data (values sampled on entry). On accept, go to RETIRE_ST.
  - RETIRE_REG: end_of_inst_reg=1 for this cycle only, then go to COMMIT.
  - RETIRE_ST: end_of_inst_store=1 for this cycle only, then go to COMMIT.
  - RETIRE_JR: no strobe, then go to COMMIT.
  - COMMIT: pc<=pc_next.
    - If pc_next==0, active<=0 and go to HALTED.
    - Otherwise go to IDLE.
  - HALTED: terminal. Ignores fetch; only reset leaves it.
- Latency with zero wait states:
  - R-type: fetch to end_of_inst_reg = 3 cycles.
  - Load: fetch to end_of_inst_reg = 4 cycles.
  - Store: fetch to end_of_inst_store = 4 cycles.
  - Each waitrequest cycle adds 1 cycle.
- Strobe exclusivity:
  - end_of_inst_reg and end_of_inst_store are never high together.
  - Each is never high for 2 consecutive cycles.
- fetch held high through the whole instruction has no effect until the sequencer is back in IDLE.

Optional Feature:
- Macro name: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every accept or state change.
  - It increments for each cycle a request is high with mem_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES, the request is dropped and bus_error<=1 (sticky until reset). active<=0 and the state goes to HALTED, with no strobe and no PC update.
- Undefined: no counter exists; the sequencer waits indefinitely; bus_error is tied 0.

Test Plan:
- Reset, then fetch=1 with the instruction at 0xBFC00000 = 32'h00851020 and no waits:
  - mem_read pulses with address 0xBFC00000.
  - inst=32'h00851020.
  - end_of_inst_reg pulses exactly 3 cycles after fetch.
  - pc becomes pc_next=0xBFC00004.
- Load with MemRead=1, alu_result=0x00001004, readdata=0xDEADBEEF and 2 waitrequest cycles:
  - Address 0x00001004 is held for 3 cycles.
  - load_data=0xDEADBEEF.
  - end_of_inst_reg pulses at cycle 6.
- Store with MemWrite=1, alu_result=0x2000, store_data=0x12345678:
  - mem_write with those values is accepted.
  - end_of_inst_store pulses once; end_of_inst_reg stays 0.
- JRcontrol=1 with pc_next=0:
  - No strobe is emitted.
  - pc=0, active=0, state HALTED.
  - A subsequent fetch=1 issues no bus request.
- Reset asserted while in LOAD with waitrequest held high:
  - mem_read=0 at the next edge.
  - No strobe; pc=RESET_PC.
- With MEM_TIMEOUT_EN defined, waitrequest held high for 16 cycles during FETCH:
  - bus_error=1, active=0, mem_read=0.
  - bus_error is cleared only by reset.
